// File: rtl/upsample2x2_nearest.sv
// -----------------------------------------------------------------------------
// upsample2x2_nearest
//
// Streaming 2x nearest-neighbour upsampler. Takes a raster-ordered feature map
// of IN_COLS x IN_ROWS pixels and emits a 2*IN_COLS x 2*IN_ROWS raster where
// every input pixel becomes a 2x2 block. Each input row is emitted twice: the
// first output row straight from the input stream (each pixel sent twice), the
// second from a one-row line buffer (again each pixel sent twice).
//
// Optional build macro: UPSAMPLE2X2_OUT_LAST_EN
//   When defined, adds the Out_Last output marking the final beat of every
//   output row. When undefined, that port and its logic are absent.
//
// Ports:
//   Clk        in   clock, rising edge
//   Rst        in   asynchronous reset, active low
//   In_Data    in   input pixel                      [DATA_WIDTH]
//   In_Valid   in   In_Data is valid
//   In_Ready   out  input accepted this cycle (combinational, independent of In_Valid)
//   Out_Data   out  output pixel, registered         [DATA_WIDTH]
//   Out_Valid  out  Out_Data is valid, registered
//   Out_Ready  in   downstream accepts Out_Data
//   Frame_Done out  one-cycle pulse after the last output handshake of a frame
//   Out_Last   out  (macro only) second copy of the last column of an output row
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------------
// S_FIRST  | first output row of a pair; accepts input pixels, fills line buffer
// S_REPEAT | second output row of a pair; replays line buffer, input stalled
//
module upsample2x2_nearest #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_COLS    = 16,
    parameter int IN_ROWS    = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
`ifdef UPSAMPLE2X2_OUT_LAST_EN
    output logic                  Out_Last,
`endif
    output logic                  Frame_Done
);

    localparam int IDX_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IN_COLS - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IN_ROWS - 1);

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_REPEAT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    rep_q, rep_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_WIDTH-1:0]    in_col_q, in_col_d;
    logic [CNT_WIDTH-1:0]    rd_col_q, rd_col_d;
    logic [CNT_WIDTH-1:0]    row_q, row_d;
    logic                    last_q, last_d;
    logic                    frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0]   line_q [0:IN_COLS-1];
    logic [DATA_WIDTH-1:0]   line_rd;

    logic                    free;
    logic                    out_xfer;
    logic                    in_xfer;
    logic                    load;
    logic                    line_we;
    logic                    in_col_last;
    logic                    rd_col_last;
    logic                    row_last;

`ifdef UPSAMPLE2X2_OUT_LAST_EN
    logic                    col_last_q, col_last_d;
    logic                    out_last_q, out_last_d;
`endif

    // The output slot can take a new pixel when empty, or when the second copy
    // of the current pixel leaves this cycle.
    assign free        = !valid_q | (Out_Ready & rep_q);
    assign out_xfer    = valid_q & Out_Ready;
    assign In_Ready    = (state_q == S_FIRST) & free;
    assign in_xfer     = In_Valid & In_Ready;
    assign load        = (state_q == S_FIRST) ? in_xfer : free;
    assign line_we     = in_xfer;
    assign in_col_last = (in_col_q == COL_LAST);
    assign rd_col_last = (rd_col_q == COL_LAST);
    assign row_last    = (row_q == ROW_LAST);
    assign line_rd     = line_q[rd_col_q[IDX_W-1:0]];

    always_comb begin
        state_d      = state_q;
        rep_d        = rep_q;
        valid_d      = valid_q;
        data_d       = data_q;
        in_col_d     = in_col_q;
        rd_col_d     = rd_col_q;
        row_d        = row_q;
        last_d       = last_q;
        frame_done_d = out_xfer & rep_q & last_q;
`ifdef UPSAMPLE2X2_OUT_LAST_EN
        col_last_d   = col_last_q;
`endif

        // Duplication: first copy leaving re-presents the same pixel; second
        // copy leaving empties the slot unless a load below refills it.
        if (out_xfer) begin
            if (!rep_q) begin
                rep_d = 1'b1;
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end

        if (load) begin
            valid_d = 1'b1;
            rep_d   = 1'b0;
            if (state_q == S_FIRST) begin
                data_d = In_Data;
                last_d = 1'b0;
`ifdef UPSAMPLE2X2_OUT_LAST_EN
                col_last_d = in_col_last;
`endif
                if (in_col_last) begin
                    in_col_d = '0;
                    state_d  = S_REPEAT;
                end else begin
                    in_col_d = in_col_q + 1'b1;
                end
            end else begin
                data_d = line_rd;
                last_d = rd_col_last & row_last;
`ifdef UPSAMPLE2X2_OUT_LAST_EN
                col_last_d = rd_col_last;
`endif
                if (rd_col_last) begin
                    rd_col_d = '0;
                    state_d  = S_FIRST;
                    if (row_last) begin
                        row_d = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    rd_col_d = rd_col_q + 1'b1;
                end
            end
        end
    end

`ifdef UPSAMPLE2X2_OUT_LAST_EN
    assign out_last_d = valid_d & rep_d & col_last_d;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_FIRST;
            rep_q        <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            in_col_q     <= '0;
            rd_col_q     <= '0;
            row_q        <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UPSAMPLE2X2_OUT_LAST_EN
            col_last_q   <= 1'b0;
            out_last_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rep_q        <= rep_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            in_col_q     <= in_col_d;
            rd_col_q     <= rd_col_d;
            row_q        <= row_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
`ifdef UPSAMPLE2X2_OUT_LAST_EN
            col_last_q   <= col_last_d;
            out_last_q   <= out_last_d;
`endif
        end
    end

    // Line buffer holds no control state, so it is left out of reset.
    always_ff @(posedge Clk) begin
        if (line_we) begin
            line_q[in_col_q[IDX_W-1:0]] <= In_Data;
        end
    end

    assign Out_Data   = data_q;
    assign Out_Valid  = valid_q;
    assign Frame_Done = frame_done_q;
`ifdef UPSAMPLE2X2_OUT_LAST_EN
    assign Out_Last   = out_last_q;
`endif

endmodule

// File: tb/tb_upsample2x2_nearest.sv
module tb_upsample2x2_nearest;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;
    int          sel;

    always #5 clk = ~clk;

    // DUT A: 2x2 frame, DUT B: 3x1 frame
    logic        a_in_valid, a_in_ready, a_out_valid, a_frame_done;
    logic [15:0] a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_frame_done;
    logic [15:0] b_out_data;
    logic        a_out_last, b_out_last;

    assign a_in_valid = in_valid && (sel == 0);
    assign b_in_valid = in_valid && (sel == 1);

    upsample2x2_nearest #(.DATA_WIDTH(16), .IN_COLS(2), .IN_ROWS(2), .CNT_WIDTH(8)) dut_a (
        .Clk(clk), .Rst(rst), .In_Data(in_data), .In_Valid(a_in_valid), .In_Ready(a_in_ready),
        .Out_Data(a_out_data), .Out_Valid(a_out_valid), .Out_Ready(out_ready),
`ifdef UPSAMPLE2X2_OUT_LAST_EN
        .Out_Last(a_out_last),
`endif
        .Frame_Done(a_frame_done)
    );

    upsample2x2_nearest #(.DATA_WIDTH(16), .IN_COLS(3), .IN_ROWS(1), .CNT_WIDTH(8)) dut_b (
        .Clk(clk), .Rst(rst), .In_Data(in_data), .In_Valid(b_in_valid), .In_Ready(b_in_ready),
        .Out_Data(b_out_data), .Out_Valid(b_out_valid), .Out_Ready(out_ready),
`ifdef UPSAMPLE2X2_OUT_LAST_EN
        .Out_Last(b_out_last),
`endif
        .Frame_Done(b_frame_done)
    );

`ifndef UPSAMPLE2X2_OUT_LAST_EN
    assign a_out_last = 1'b0;
    assign b_out_last = 1'b0;
`endif

    logic        t_in_ready, t_out_valid, t_frame_done, t_out_last;
    logic [15:0] t_out_data;
    assign t_in_ready   = (sel == 0) ? a_in_ready   : b_in_ready;
    assign t_out_valid  = (sel == 0) ? a_out_valid  : b_out_valid;
    assign t_frame_done = (sel == 0) ? a_frame_done : b_frame_done;
    assign t_out_data   = (sel == 0) ? a_out_data   : b_out_data;
    assign t_out_last   = (sel == 0) ? a_out_last   : b_out_last;

    logic [15:0] ins[$];
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    logic        got_last[$];
    int          got_cyc[$];
    int          fd_cyc[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    // Drives the selected DUT from ins[], records every output handshake.
    task automatic run(input int n_exp, input bit toggle, input int gap,
                       input int abort_after, input bit chk_rep);
        int ip = 0;
        int cyc = 0;
        int hold = 0;
        bit prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        got.delete(); got_cyc.delete(); fd_cyc.delete(); got_last.delete();
        while (got.size() < n_exp && cyc < 300 &&
               !(abort_after > 0 && got.size() >= abort_after)) begin
            @(negedge clk);
            if (t_frame_done) fd_cyc.push_back(cyc);
            in_valid  = (ip < ins.size()) && (hold == 0);
            in_data   = (ip < ins.size()) ? ins[ip] : 16'h0;
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (prev_stall) begin
                vec_cnt++;
                if (t_out_valid !== 1'b1 || t_out_data !== prev_data) begin
                    err_cnt++;
                    $display("FAIL hold_stable: got valid=%b data=%0d expected valid=1 data=%0d",
                             t_out_valid, t_out_data, prev_data);
                end
            end
            prev_stall = t_out_valid && !out_ready;
            prev_data  = t_out_data;
            if (prev_stall) begin
                vec_cnt++;
                if (t_in_ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL in_ready_stall: got %b expected 0", t_in_ready);
                end
            end
            if (chk_rep && t_out_valid && got.size() >= 4 && got.size() <= 9) begin
                vec_cnt++;
                if (t_in_ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL in_ready_repeat: idx %0d got %b expected 0", got.size(), t_in_ready);
                end
            end
            if (t_out_valid && out_ready) begin
                got.push_back(t_out_data);
                got_cyc.push_back(cyc);
                got_last.push_back(t_out_last);
            end
            if (in_valid && t_in_ready) begin
                ip++;
                hold = gap;
            end else if (hold > 0) begin
                hold--;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (abort_after == 0) begin
            repeat (3) begin
                @(negedge clk);
                if (t_frame_done) fd_cyc.push_back(cyc);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vec_cnt++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_frame_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_a_out: got v=%b d=%0d fd=%b expected 0 0 0", a_out_valid, a_out_data, a_frame_done);
        end
        vec_cnt++;
        if (a_in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_a_in_ready: got %b expected 1", a_in_ready);
        end
        vec_cnt++;
        if (b_out_valid !== 1'b0 || b_out_data !== 16'd0 || b_in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_b: got v=%b d=%0d rdy=%b expected 0 0 1", b_out_valid, b_out_data, b_in_ready);
        end
    endtask

    task automatic test_basic();
        sel = 0;
        ins   = '{16'd1, 16'd2, 16'd3, 16'd4};
        exp_q = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
        run(16, 1'b0, 0, 0, 1'b0);
        vec_cnt++;
        if (got.size() != 16) begin
            err_cnt++;
            $display("FAIL basic_count: got %0d expected 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
`ifdef UPSAMPLE2X2_OUT_LAST_EN
            vec_cnt++;
            if (got_last[i] !== (i % 4 == 3)) begin
                err_cnt++;
                $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], (i % 4 == 3));
            end
`endif
        end
        if (got.size() == 16) begin
            vec_cnt++;
            if (got_cyc[15] - got_cyc[0] != 15) begin
                err_cnt++;
                $display("FAIL basic_span: got %0d cycles expected 15", got_cyc[15] - got_cyc[0]);
            end
            vec_cnt++;
            if (fd_cyc.size() != 1 || fd_cyc[0] != got_cyc[15] + 1) begin
                err_cnt++;
                $display("FAIL basic_frame_done: got %0d pulses expected 1 at cycle %0d", fd_cyc.size(), got_cyc[15] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        sel = 0;
        ins   = '{16'd1, 16'd2, 16'd3, 16'd4};
        exp_q = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
        run(16, 1'b1, 0, 0, 1'b0);
        vec_cnt++;
        if (got.size() != 16) begin
            err_cnt++;
            $display("FAIL bp_count: got %0d expected 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
        end
        vec_cnt++;
        if (fd_cyc.size() != 1) begin
            err_cnt++;
            $display("FAIL bp_frame_done: got %0d pulses expected 1", fd_cyc.size());
        end
    endtask

    task automatic test_gapped();
        sel = 1;
        ins   = '{16'd7, 16'd8, 16'd9};
        exp_q = '{7,7,8,8,9,9,7,7,8,8,9,9};
        run(12, 1'b0, 4, 0, 1'b1);
        vec_cnt++;
        if (got.size() != 12) begin
            err_cnt++;
            $display("FAIL gap_count: got %0d expected 12", got.size());
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL gap_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
`ifdef UPSAMPLE2X2_OUT_LAST_EN
            vec_cnt++;
            if (got_last[i] !== (i % 6 == 5)) begin
                err_cnt++;
                $display("FAIL gap_last[%0d]: got %b expected %b", i, got_last[i], (i % 6 == 5));
            end
`endif
        end
        vec_cnt++;
        if (fd_cyc.size() != 1) begin
            err_cnt++;
            $display("FAIL gap_frame_done: got %0d pulses expected 1", fd_cyc.size());
        end
        sel = 0;
    endtask

    task automatic test_back_to_back();
        sel = 0;
        ins   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_q = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4,
                  5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8};
        run(32, 1'b0, 0, 0, 1'b0);
        vec_cnt++;
        if (got.size() != 32) begin
            err_cnt++;
            $display("FAIL b2b_count: got %0d expected 32", got.size());
        end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
        end
        if (got.size() == 32) begin
            vec_cnt++;
            if (got_cyc[31] - got_cyc[0] != 31) begin
                err_cnt++;
                $display("FAIL b2b_span: got %0d cycles expected 31", got_cyc[31] - got_cyc[0]);
            end
            vec_cnt++;
            if (fd_cyc.size() != 2 || fd_cyc[0] != got_cyc[15] + 1 || fd_cyc[1] != got_cyc[31] + 1) begin
                err_cnt++;
                $display("FAIL b2b_frame_done: got %0d pulses expected 2 at cycles %0d,%0d",
                         fd_cyc.size(), got_cyc[15] + 1, got_cyc[31] + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        ins = '{16'd1, 16'd2, 16'd3, 16'd4};
        run(16, 1'b0, 0, 5, 1'b0);
        vec_cnt++;
        if (got.size() != 5) begin
            err_cnt++;
            $display("FAIL rst_mid_count: got %0d expected 5", got.size());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (a_out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_async: got valid %b expected 0", a_out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_frame_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_release: got v=%b rdy=%b fd=%b expected 0 1 0", a_out_valid, a_in_ready, a_frame_done);
        end
        ins   = '{16'd9, 16'd10, 16'd11, 16'd12};
        exp_q = '{9,9,10,10,9,9,10,10,11,11,12,12,11,11,12,12};
        run(16, 1'b0, 0, 0, 1'b0);
        vec_cnt++;
        if (got.size() != 16) begin
            err_cnt++;
            $display("FAIL rst_mid_count2: got %0d expected 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL rst_mid_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
        end
        vec_cnt++;
        if (fd_cyc.size() != 1) begin
            err_cnt++;
            $display("FAIL rst_mid_frame_done: got %0d pulses expected 1", fd_cyc.size());
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
